multicycle_control_fsm: RTL and testbench

Main control state machine of the multicycle CPU. It sequences each instruction through fetch, decode, execute, memory and writeback states. It drives every datapath control strobe, including pc_en, the write enable consumed directly by the program counter register; pc_source steers the next-PC mux feeding that register. It also waits on a memory ready handshake and counts retired instructions.

---
 rtl/multicycle_control_fsm.sv | 167 ++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Main control sequencer for the multicycle CPU: walks each instruction through
// fetch/decode/execute/memory/writeback, drives datapath strobes and counts retirements.
module multicycle_control_fsm #(
   parameter logic [5:0] OP_RTYPE = 6'b000000,
   parameter logic [5:0] OP_LW    = 6'b100011,
   parameter logic [5:0] OP_SW    = 6'b101011,
   parameter logic [5:0] OP_BEQ   = 6'b000100,
   parameter logic [5:0] OP_J     = 6'b000010,
   parameter logic [5:0] OP_ADDI  = 6'b001000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  opcode,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        pc_en,
   output logic [1:0]  pc_source,
   output logic        iord,
   output logic        mem_read,
   output logic        mem_write,
   output logic        ir_write,
   output logic        mem_to_reg,
   output logic        reg_dst,
   output logic        reg_write,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  alu_op,
   output logic [3:0]  state,
   output logic        illegal,
   output logic [31:0] instr_count
);

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_EXECUTE   = 4'd6,
      S_R_WB      = 4'd7,
      S_BRANCH    = 4'd8,
      S_JUMP      = 4'd9,
      S_ADDI_EX   = 4'd10,
      S_ADDI_WB   = 4'd11
   } state_t;

   state_t state_q;
   logic   pc_write;
   logic   pc_write_cond;

   assign state = state_q;
   assign pc_en = pc_write | (pc_write_cond & zero);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_FETCH;
         illegal     <= 1'b0;
         instr_count <= 32'd0;
      end else begin
         illegal <= 1'b0;
         case (state_q)
            S_FETCH:
               if (mem_ready) state_q <= S_DECODE;
            S_DECODE:
               case (opcode)
                  OP_LW, OP_SW: state_q <= S_MEM_ADDR;
                  OP_RTYPE:     state_q <= S_EXECUTE;
                  OP_BEQ:       state_q <= S_BRANCH;
                  OP_J:         state_q <= S_JUMP;
                  OP_ADDI:      state_q <= S_ADDI_EX;
                  default: begin
                     state_q <= S_FETCH;
                     illegal <= 1'b1;
                  end
               endcase
            S_MEM_ADDR:
               state_q <= (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:
               if (mem_ready) state_q <= S_MEM_WB;
            S_MEM_WRITE:
               if (mem_ready) begin
                  state_q     <= S_FETCH;
                  instr_count <= instr_count + 32'd1;
               end
            S_EXECUTE:
               state_q <= S_R_WB;
            S_ADDI_EX:
               state_q <= S_ADDI_WB;
            S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: begin
               state_q     <= S_FETCH;
               instr_count <= instr_count + 32'd1;
            end
            default:
               state_q <= S_FETCH;
         endcase
      end
   end

   // Outputs are decoded straight from state so that FETCH strobes are live on the
   // first cycle after reset while still being forced low during reset.
   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_source     = 2'd0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'd0;
      alu_op        = 2'd0;
      if (!reset) begin
         case (state_q)
            S_FETCH: begin
               mem_read  = 1'b1;
               alu_src_b = 2'd1;
               ir_write  = mem_ready;
               pc_write  = mem_ready;
            end
            S_DECODE:
               alu_src_b = 2'd3;
            S_MEM_ADDR, S_ADDI_EX: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'd2;
            end
            S_MEM_READ: begin
               mem_read = 1'b1;
               iord     = 1'b1;
            end
            S_MEM_WB: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
               mem_write = 1'b1;
               iord      = 1'b1;
            end
            S_EXECUTE: begin
               alu_src_a = 1'b1;
               alu_op    = 2'd2;
            end
            S_R_WB: begin
               reg_write = 1'b1;
               reg_dst   = 1'b1;
            end
            S_BRANCH: begin
               alu_src_a     = 1'b1;
               alu_op        = 2'd1;
               pc_source     = 2'd1;
               pc_write_cond = 1'b1;
            end
            S_JUMP: begin
               pc_write  = 1'b1;
               pc_source = 2'd2;
            end
            S_ADDI_WB:
               reg_write = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: random instruction stream with random memory
// stalls, checked per cycle against a route-per-opcode reference model.
module tb_multicycle_control_fsm;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [5:0]  opcode = 6'd0;
   logic        zero = 1'b0;
   logic        mem_ready = 1'b0;
   logic        pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg;
   logic        reg_dst, reg_write, alu_src_a, illegal;
   logic [1:0]  pc_source, alu_src_b, alu_op;
   logic [3:0]  state;
   logic [31:0] instr_count;

   multicycle_control_fsm dut (
      .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .pc_en(pc_en), .pc_source(pc_source), .iord(iord), .mem_read(mem_read),
      .mem_write(mem_write), .ir_write(ir_write), .mem_to_reg(mem_to_reg),
      .reg_dst(reg_dst), .reg_write(reg_write), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .state(state), .illegal(illegal),
      .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   localparam logic [5:0] OP_RTYPE = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                          OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] exp_cnt = 32'd0;
   logic        exp_ill = 1'b0;
   int          route[$];
   int          zsel = 2;          // 2 = random zero flag, else forced value
   int          stall_fetch = -1;  // >=0: exact FETCH stall cycles
   int          stall_mem = -1;    // >=0: exact MEM_READ/MEM_WRITE stall cycles
   int          last_cycles;

   // {pc_en, pc_source, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
   //  reg_write, alu_src_a, alu_src_b, alu_op}
   wire [14:0] ctl = {pc_en, pc_source, iord, mem_read, mem_write, ir_write, mem_to_reg,
                      reg_dst, reg_write, alu_src_a, alu_src_b, alu_op};

   function automatic logic [14:0] exp_ctl(int ph, logic mr, logic z);
      case (ph)
         0:  return {mr,   2'd0, 1'b0, 1'b1, 1'b0, mr,   1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0};
         1:  return {1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 2'd0};
         2:  return {1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd0};
         3:  return {1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
         4:  return {1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0};
         5:  return {1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
         6:  return {1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd2};
         7:  return {1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0};
         8:  return {z,    2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd1};
         9:  return {1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
         10: return {1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd0};
         11: return {1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0};
         default: return 15'd0;
      endcase
   endfunction

   function automatic bit legal(logic [5:0] op);
      return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
   endfunction

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Sequence of states an opcode visits, ignoring stall repeats.
   task automatic build_route(input logic [5:0] op);
      case (op)
         OP_LW:    route = '{0, 1, 2, 3, 4};
         OP_SW:    route = '{0, 1, 2, 5};
         OP_RTYPE: route = '{0, 1, 6, 7};
         OP_BEQ:   route = '{0, 1, 8};
         OP_J:     route = '{0, 1, 9};
         OP_ADDI:  route = '{0, 1, 10, 11};
         default:  route = '{0, 1};
      endcase
   endtask

   task automatic run_instr(input logic [5:0] op);
      build_route(op);
      last_cycles = 0;
      foreach (route[i]) begin
         int  n = 0;
         int  lim;
         bit  waits;
         bit  stay;
         waits = route[i] inside {0, 3, 5};
         lim = (route[i] == 0) ? stall_fetch : stall_mem;
         do begin
            @(negedge clk);
            opcode = op;
            zero = (zsel == 2) ? 1'($urandom_range(0, 1)) : 1'(zsel);
            if (!waits)        mem_ready = 1'($urandom_range(0, 1));
            else if (lim >= 0) mem_ready = (n >= lim);
            else               mem_ready = (n >= 5) || ($urandom_range(0, 99) < 70);
            #1;
            check("state", 32'(state), 32'(route[i]));
            check("ctl", 32'(ctl), 32'(exp_ctl(route[i], mem_ready, zero)));
            check("illegal", 32'(illegal), 32'(exp_ill));
            check("instr_count", instr_count, exp_cnt);
            exp_ill = 1'b0;
            stay = waits && !mem_ready;
            n++;
            last_cycles++;
         end while (stay);
      end
      if (legal(op)) exp_cnt = exp_cnt + 32'd1;
      else           exp_ill = 1'b1;
   endtask

   function automatic logic [5:0] rand_op();
      logic [5:0] ops [6];
      ops = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
      if ($urandom_range(0, 99) < 12) return 6'($urandom_range(0, 63));
      return ops[$urandom_range(0, 5)];
   endfunction

   initial begin
      // Reset state: everything low even with mem_ready high in FETCH.
      mem_ready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check("rst_state", 32'(state), 32'd0);
      check("rst_ctl", 32'(ctl), 32'd0);
      check("rst_illegal", 32'(illegal), 32'd0);
      check("rst_count", instr_count, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      mem_ready = 1'b0;

      stall_fetch = 0; stall_mem = 0;
      run_instr(OP_RTYPE);
      check("rtype_lat", 32'(last_cycles), 32'd4);
      run_instr(OP_LW);
      check("lw_lat", 32'(last_cycles), 32'd5);
      run_instr(OP_BEQ);
      check("beq_lat", 32'(last_cycles), 32'd3);
      stall_fetch = 3; stall_mem = 2;
      run_instr(OP_LW);
      check("lw_stall_lat", 32'(last_cycles), 32'd10);
      stall_fetch = 0; stall_mem = 0;

      // Async reset in the middle of MEM_READ.
      @(negedge clk); opcode = OP_LW; mem_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk); mem_ready = 1'b0;
      #1;
      check("pre_rst_state", 32'(state), 32'd3);
      #1 reset = 1'b1;
      #1;
      check("mid_rst_state", 32'(state), 32'd0);
      check("mid_rst_ctl", 32'(ctl), 32'd0);
      check("mid_rst_count", instr_count, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      exp_cnt = 32'd0;
      exp_ill = 1'b0;
      run_instr(OP_SW);

      zsel = 1; run_instr(OP_BEQ);
      zsel = 0; run_instr(OP_BEQ);
      zsel = 2;
      run_instr(6'b111111);
      run_instr(OP_ADDI);
      run_instr(OP_J);

      stall_fetch = -1; stall_mem = -1;
      for (int k = 0; k < 300; k++) run_instr(rand_op());
      run_instr(OP_RTYPE);

      // Counter wrap: preload all-ones during a FETCH stall, then retire a jump.
      @(negedge clk);
      mem_ready = 1'b0;
      force dut.instr_count = 32'hFFFF_FFFF;
      #1 release dut.instr_count;
      exp_cnt = 32'hFFFF_FFFF;
      stall_fetch = 0;
      run_instr(OP_J);
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      check("wrap_count", instr_count, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout observed=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
